serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_if.sv | 25 ++
 rtl/serial_adder.sv | 94 +++++++++
 tb/tb_serial_adder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder: operands and start in,
// busy/done status and the registered result out.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;

  modport master (
    output start, a, b, ci,
    input  busy, done, sum, co, ovf
  );

  modport slave (
    input  start, a, b, ci,
    output busy, done, sum, co, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one bit per clock, LSB first, WIDTH+1 edges from
// accepted start to the done pulse, with carry-out and signed overflow flags.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_r;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;

  logic s;
  logic c_next;
  logic last_bit;

  // Full-adder slice on the current LSBs of the operand shift registers.
  assign s        = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_next   = (a_sr[0] & b_sr[0]) | (b_sr[0] & carry) | (a_sr[0] & carry);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let the carry race the sum bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_r  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      ovf_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            carry  <= bus.ci;
            sum_r  <= '0;
            cnt    <= '0;
            ovf_r  <= 1'b0;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          sum_r <= {s, sum_r[WIDTH-1:1]};
          carry <= c_next;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            // Carry into the MSB is the current carry; carry out is c_next.
            ovf_r  <= carry ^ c_next;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.co   = carry;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases, back-to-back,
// mid-run reset and randomized operands against an arithmetic reference.
module tb_serial_adder;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       output logic [W-1:0] e_sum, output logic e_co, output logic e_ovf);
    int total;
    int sa;
    int sb;
    int ssum;
    total = int'(a) + int'(b) + int'(ci);
    e_sum = W'(total % (2 ** W));
    e_co  = (total >= 2 ** W);
    sa    = (int'(a) >= 2 ** (W - 1)) ? int'(a) - 2 ** W : int'(a);
    sb    = (int'(b) >= 2 ** (W - 1)) ? int'(b) - 2 ** W : int'(b);
    ssum  = sa + sb + int'(ci);
    e_ovf = (ssum > 2 ** (W - 1) - 1) || (ssum < -(2 ** (W - 1)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation with operands and start scrambled while it runs.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input string tag);
    logic [W-1:0] e_sum;
    logic         e_co;
    logic         e_ovf;
    model(a, b, ci, e_sum, e_co, e_ovf);
    bus.a     = a;
    bus.b     = b;
    bus.ci    = ci;
    bus.start = 1'b1;
    tick();
    check($sformatf("%s busy@accept", tag), 64'(bus.busy), 64'd1);
    for (int i = 1; i <= W + 1; i++) begin
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.ci    = 1'($urandom);
      bus.start = 1'($urandom);
      tick();
      if (i < W) begin
        check($sformatf("%s busy run%0d", tag, i), 64'({bus.busy, bus.done}), 64'b10);
      end else if (i == W) begin
        check($sformatf("%s done", tag), 64'({bus.busy, bus.done}), 64'b01);
        check($sformatf("%s sum", tag), 64'(bus.sum), 64'(e_sum));
        check($sformatf("%s co/ovf", tag), 64'({bus.co, bus.ovf}), 64'({e_co, e_ovf}));
      end else begin
        check($sformatf("%s idle after done", tag), 64'({bus.busy, bus.done}), 64'b00);
        check($sformatf("%s sum held", tag), 64'(bus.sum), 64'(e_sum));
      end
    end
    bus.start = 1'b0;
    tick();
    check($sformatf("%s idle hold", tag), 64'({bus.busy, bus.done, bus.sum, bus.co, bus.ovf}),
          64'({2'b00, e_sum, e_co, e_ovf}));
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.ci    = 1'b0;
    tick();
    check("reset outputs", 64'({bus.busy, bus.done, bus.sum, bus.co, bus.ovf}), 64'd0);
    tick();

    // Release between edges; the start driven now meets the first live edge.
    rst_n = 1'b1;
    run_op(8'h0F, 8'h01, 1'b0, "0f+01");
    run_op(8'hFF, 8'h01, 1'b0, "ff+01");
    run_op(8'h7F, 8'h01, 1'b0, "7f+01");
    run_op(8'hFF, 8'hFF, 1'b1, "ff+ff+1");
    run_op(8'h80, 8'hFF, 1'b0, "80+ff");
    run_op(8'h00, 8'h00, 1'b1, "00+00+1");

    // Back-to-back with start held high and operands swapped during RUN.
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    bus.ci    = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.a = 8'hAA;
    bus.b = 8'h55;
    for (int i = 1; i <= W; i++) tick();
    check("b2b first done", 64'({bus.done, bus.sum}), 64'({1'b1, 8'h46}));
    tick();
    check("b2b gap", 64'({bus.busy, bus.done}), 64'b00);
    tick();
    check("b2b second accepted", 64'({bus.busy, bus.done}), 64'b10);
    for (int i = 1; i < W; i++) tick();
    check("b2b not early", 64'(bus.done), 64'd0);
    tick();
    check("b2b second done", 64'({bus.done, bus.sum, bus.co, bus.ovf}),
          64'({1'b1, 8'hFF, 1'b0, 1'b0}));
    bus.start = 1'b0;
    tick();
    tick();

    // Reset in the middle of RUN after four bits have been processed.
    bus.a     = 8'h5A;
    bus.b     = 8'h3C;
    bus.ci    = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async reset clears", 64'({bus.busy, bus.done, bus.sum, bus.co, bus.ovf}), 64'd0);
    tick();
    check("no done in reset", 64'({bus.busy, bus.done}), 64'b00);
    rst_n = 1'b1;
    tick();
    check("idle after reset", 64'({bus.busy, bus.done}), 64'b00);
    run_op(8'h80, 8'h80, 1'b0, "80+80");

    for (int n = 0; n < 20; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
